// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared operation encodings, FSM state encoding and default width
// for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/result bundle of the multiply/divide unit.
// master drives the request side, slave is the unit itself.
interface muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             flush;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, in1, in2, flush,
                  input  busy, done, div_zero, hi, lo);
  modport slave  (input  start, op, in1, in2, flush,
                  output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of shift-add multiply or
// restoring divide. A single (WIDTH+1)-bit adder serves both: multiply adds
// the multiplicand when the multiplier LSB is set, divide subtracts the
// divisor from the left-shifted partial remainder.
module muldiv_step #(parameter int WIDTH = 32) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mq,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] mq_nxt
);

  logic [WIDTH:0] add_a;
  logic [WIDTH:0] add_b;
  logic           add_cin;
  logic [WIDTH:0] sum;

  // Select adder operands, then shift the result into acc/mq.
  always_comb begin
    add_a   = {1'b0, acc};
    add_b   = '0;
    add_cin = 1'b0;
    acc_nxt = acc;
    mq_nxt  = mq;
    if (is_div) begin
      add_a   = {acc, mq[WIDTH-1]};
      add_b   = ~{1'b0, opnd};
      add_cin = 1'b1;
    end else if (mq[0]) begin
      add_b   = {1'b0, opnd};
    end
    sum = add_a + add_b + {{WIDTH{1'b0}}, add_cin};
    if (is_div) begin
      // Top bit set means the trial subtraction went negative: restore.
      if (!sum[WIDTH]) begin
        acc_nxt = sum[WIDTH-1:0];
        mq_nxt  = {mq[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = add_a[WIDTH-1:0];
        mq_nxt  = {mq[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_nxt = sum[WIDTH:1];
      mq_nxt  = {sum[0], mq[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: HI/LO multiply/divide unit with IDLE/RUN/DONE control.
// Signed ops run on magnitudes and fix the signs when the result is written.
// Build option: define MULDIV_FAST_MUL_EN for single-cycle MULT/MULTU.
module muldiv_unit
  import muldiv_pkg::*;
#(parameter int WIDTH = DEFAULT_WIDTH) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [WIDTH-1:0]        acc_q, acc_d, mq_q, mq_d, opnd_q, opnd_d;
  logic [WIDTH-1:0]        a_raw_q, a_raw_d, hi_q, hi_d, lo_q, lo_d;
  logic                    is_div_q, is_div_d, neg_res_q, neg_res_d;
  logic                    neg_rem_q, neg_rem_d, dz_q, dz_d;
  logic                    div_zero_q, div_zero_d;
  logic [WIDTH-1:0]        acc_nxt, mq_nxt, mag1, mag2;
  logic signed [WIDTH-1:0] in1_s, in2_s;
  logic                    signed_op, sgn1, sgn2, accept;
  op_e                     op_in;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x,
                                                input logic neg);
    return neg ? -x : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_w(input logic [2*WIDTH-1:0] x,
                                                    input logic neg);
    return neg ? -x : x;
  endfunction

  assign op_in     = op_e'(bus.op);
  assign in1_s     = bus.in1;
  assign in2_s     = bus.in2;
  assign signed_op = (op_in == OP_MULT) || (op_in == OP_DIV);
  assign sgn1      = signed_op && (in1_s < 0);
  assign sgn2      = signed_op && (in2_s < 0);
  assign mag1      = cond_neg(bus.in1, sgn1);
  assign mag2      = cond_neg(bus.in2, sgn2);
  assign accept    = (state_q != ST_RUN) && bus.start && !bus.flush;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, mag1} * {{WIDTH{1'b0}}, mag2};
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div_q),
    .acc     (acc_q),
    .mq      (mq_q),
    .opnd    (opnd_q),
    .acc_nxt (acc_nxt),
    .mq_nxt  (mq_nxt)
  );

  // Next-state, operand capture, iteration and result write-back.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mq_d       = mq_q;
    opnd_d     = opnd_q;
    a_raw_d    = a_raw_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    dz_d       = dz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = acc_nxt;
          mq_d  = mq_nxt;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = ST_DONE;
            if (!is_div_q) begin
              {hi_d, lo_d} = cond_neg_w({acc_nxt, mq_nxt}, neg_res_q);
            end else if (dz_q) begin
              hi_d       = a_raw_q;
              lo_d       = '1;
              div_zero_d = 1'b1;
            end else begin
              lo_d = cond_neg(mq_nxt, neg_res_q);
              hi_d = cond_neg(acc_nxt, neg_rem_q);
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (accept) begin
          case (op_in)
            OP_MULT, OP_MULTU: begin
`ifdef MULDIV_FAST_MUL_EN
              {hi_d, lo_d} = cond_neg_w(fast_prod, sgn1 ^ sgn2);
              state_d      = ST_DONE;
`else
              state_d   = ST_RUN;
              cnt_d     = '0;
              acc_d     = '0;
              is_div_d  = 1'b0;
              opnd_d    = mag1;
              mq_d      = mag2;
              neg_res_d = sgn1 ^ sgn2;
`endif
            end
            OP_DIV, OP_DIVU: begin
              state_d   = ST_RUN;
              cnt_d     = '0;
              acc_d     = '0;
              is_div_d  = 1'b1;
              opnd_d    = mag2;
              mq_d      = mag1;
              neg_res_d = sgn1 ^ sgn2;
              neg_rem_d = sgn1;
              dz_d      = (bus.in2 == '0);
              a_raw_d   = bus.in1;
            end
            OP_MTHI: hi_d = bus.in1;
            OP_MTLO: lo_d = bus.in1;
            default: ;
          endcase
        end
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      mq_q       <= '0;
      opnd_q     <= '0;
      a_raw_q    <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      mq_q       <= mq_d;
      opnd_q     <= opnd_d;
      a_raw_q    <= a_raw_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      dz_q       <= dz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.busy     = (state_q == ST_RUN);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.div_zero = div_zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit (WIDTH=32).
// Define MULDIV_FAST_MUL_EN when building against the single-cycle multiply.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int          MUL_LAT = 0;
  localparam logic [2:0]  IGN_OP  = 3'd2;          // DIV -2 / 3
  localparam logic [31:0] IGN_HI  = 32'hFFFFFFFE;
  localparam logic [31:0] IGN_LO  = 32'h00000000;
`else
  localparam int          MUL_LAT = W;
  localparam logic [2:0]  IGN_OP  = 3'd0;          // MULT -2 * 3
  localparam logic [31:0] IGN_HI  = 32'hFFFFFFFF;
  localparam logic [31:0] IGN_LO  = 32'hFFFFFFFA;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Present a request, let the next rising edge take it, then drop start.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.in1   = a;
    bus.in2   = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input logic exp_dz, input int exp_lat);
    int lat;
    issue(op, a, b);
    chk({tag, ".busy"}, bus.busy, (exp_lat > 0) ? 1 : 0);
    wait_done(lat);
    chk({tag, ".lat"}, lat, exp_lat);
    chk({tag, ".hi"}, bus.hi, exp_hi);
    chk({tag, ".lo"}, bus.lo, exp_lo);
    chk({tag, ".dz"}, bus.div_zero, exp_dz);
    @(posedge clk);
    #1;
    chk({tag, ".done_pulse"}, bus.done, 0);
  endtask

  initial begin
    int lat;
    int seen;
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = '0;
    bus.in1   = '0;
    bus.in2   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", bus.busy, 0);
    chk("rst.done", bus.done, 0);
    chk("rst.dz",   bus.div_zero, 0);
    chk("rst.hi",   bus.hi, 0);
    chk("rst.lo",   bus.lo, 0);

    // Release reset mid-cycle; first request must be taken on the next edge.
    @(negedge clk);
    rst_n = 1'b1;
    run_op("mult_m1x7", OP_MULT, 32'hFFFFFFFF, 32'd7,
           32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0, MUL_LAT);
    run_op("multu_ffx7", OP_MULTU, 32'hFFFFFFFF, 32'd7,
           32'h00000006, 32'hFFFFFFF9, 1'b0, MUL_LAT);
    run_op("div_m7d2", OP_DIV, 32'hFFFFFFF9, 32'd2,
           32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, W);
    run_op("divu_dz", OP_DIVU, 32'h00001234, 32'd0,
           32'h00001234, 32'hFFFFFFFF, 1'b1, W);
    run_op("div_minneg", OP_DIV, 32'h80000000, 32'hFFFFFFFF,
           32'h00000000, 32'h80000000, 1'b0, W);

    // DIVU 100/7 followed by a request issued in the DONE cycle.
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_done(lat);
    chk("divu_100_7.lat", lat, W);
    chk("divu_100_7.lo", bus.lo, 14);
    chk("divu_100_7.hi", bus.hi, 2);
    issue(OP_DIVU, 32'd9, 32'd3);
    chk("b2b.busy", bus.busy, 1);
    wait_done(lat);
    chk("b2b.lat", lat, W);
    chk("b2b.lo", bus.lo, 3);
    chk("b2b.hi", bus.hi, 0);
    @(posedge clk);
    #1;

    // Requests and operand changes while busy must not disturb the operation.
    issue(IGN_OP, 32'hFFFFFFFE, 32'd3);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (lat == 4) begin
        bus.start = 1'b1;
        bus.op    = OP_DIVU;
        bus.in1   = 32'd1000;
        bus.in2   = 32'd9;
      end else if (lat == 5) begin
        bus.start = 1'b0;
      end
      if (lat == 9) bus.in1 = 32'h55;
      @(posedge clk);
      #1;
      lat++;
    end
    chk("ign.lat", lat, W);
    chk("ign.hi", bus.hi, IGN_HI);
    chk("ign.lo", bus.lo, IGN_LO);
    @(posedge clk);
    #1;
    chk("ign.no_replay", bus.busy, 0);

    // Flush mid-divide: back to IDLE, HI/LO untouched, no done afterwards.
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    #1;
    chk("flush.hold_hi", bus.hi, IGN_HI);
    repeat (5) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    chk("flush.busy", bus.busy, 0);
    chk("flush.hi", bus.hi, IGN_HI);
    chk("flush.lo", bus.lo, IGN_LO);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) seen++;
    end
    chk("flush.no_done", seen, 0);

    // Flush and start together in IDLE: the request is dropped.
    bus.flush = 1'b1;
    issue(OP_DIVU, 32'd9, 32'd3);
    bus.flush = 1'b0;
    chk("flush_start.busy", bus.busy, 0);
    @(posedge clk);
    #1;
    chk("flush_start.done", bus.done, 0);

    // Asynchronous reset in the middle of a divide.
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (14) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst.busy", bus.busy, 0);
    chk("arst.done", bus.done, 0);
    chk("arst.hi", bus.hi, 0);
    chk("arst.lo", bus.lo, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Moves into HI and LO.
    issue(OP_MTHI, 32'hA5A5A5A5, 32'd0);
    chk("mthi.hi", bus.hi, 32'hA5A5A5A5);
    chk("mthi.busy", bus.busy, 0);
    chk("mthi.done", bus.done, 0);
    issue(OP_MTLO, 32'h5A5A5A5A, 32'd0);
    chk("mtlo.lo", bus.lo, 32'h5A5A5A5A);
    chk("mtlo.hi", bus.hi, 32'hA5A5A5A5);
    chk("mtlo.busy", bus.busy, 0);
    chk("mtlo.done", bus.done, 0);

    run_op("multu_3x5", OP_MULTU, 32'd3, 32'd5,
           32'd0, 32'd15, 1'b0, MUL_LAT);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
